fb_access_arbiter: RTL and testbench
====================================

// Module: fb_access_arbiter
// PURPOSE
//  Shares one single-port framebuffer RAM (1-cycle read latency) between the display
//  fetch path that feeds vga_out draw_r/g/b and two game-logic writers.
//  Display reads have absolute priority. Writers share the remaining slots round-robin,
//  in bursts of at most MAX_BURST beats. Writers can optionally be restricted to vblank.
// PARAMETERS
//  ADDR_W          14   framebuffer word address width (160x100 = 16000 words)
//  DATA_W          12   pixel word width, {r[3:0],g[3:0],b[3:0]}
//  MAX_BURST       8    max write beats per grant, legal range 1..255
//  WR_VBLANK_ONLY  0    1: writer grants only while vblank=1
// PORTS
//  clk          in   1         system/pixel clock
//  rst          in   1         reset, synchronous, active-high
//  vblank       in   1         1 outside visible rows, from timing generator
//  disp_req     in   1         display read request, one word per cycle asserted
//  disp_addr    in   ADDR_W    display read address
//  disp_rvalid  out  1         disp_rdata valid
//  disp_rdata   out  DATA_W    read data, in request order
//  wr_req       in   2         writer i has a beat pending
//  wr_last      in   2         pending beat is the final beat of writer i's burst
//  wr_addr      in   2*ADDR_W  writer i address, bits [i*ADDR_W +: ADDR_W]
//  wr_data      in   2*DATA_W  writer i data, bits [i*DATA_W +: DATA_W]
//  wr_gnt       out  2         beat of writer i accepted at this clock edge, one-hot or 0
//  ram_en       out  1         RAM access enable, registered
//  ram_we       out  1         1 = write, registered
//  ram_addr     out  ADDR_W    registered
//  ram_wdata    out  DATA_W    registered
//  ram_rdata    in   DATA_W    valid the cycle after ram_en && !ram_we
// BEHAVIOUR
//  - Slot selection is per cycle N:
//    disp_req=1 -> display slot; wr_gnt=0.
//    Otherwise, an eligible writer may take the slot.
//  - Writer eligibility: wr_req[i]=1, and (WR_VBLANK_ONLY=0 or vblank=1).
//  - wr_gnt is combinational from state, disp_req, wr_req and vblank.
//    The writer advances its beat on clk when wr_gnt[i]=1.
//  - Cycle N+1: ram_en/ram_we/ram_addr/ram_wdata carry the slot chosen in cycle N.
//    With no slot, ram_en=0 and ram_we=0.
//  - Display read latency is 3: disp_req at N -> RAM access at N+1 -> ram_rdata at N+2
//    -> disp_rvalid=1 and disp_rdata registered at N+3. Back-to-back reads give one word
//    per cycle.
//  - FSM IDLE:
//    if no display slot and >=1 writer is eligible, grant writer i = eligible one, or
//    rr_ptr on a tie. Beat count = 1.
//    If wr_last[i] or MAX_BURST=1: stay IDLE and set rr_ptr = ~i.
//    Otherwise go to BURST with owner=i.
//  - FSM BURST(owner):
//    disp_req=1, or owner ineligible only because of vblank -> pause: no grant, counter
//    held, stay in BURST.
//    wr_req[owner]=0 -> release: go IDLE, rr_ptr = ~owner, no grant this cycle.
//    Otherwise grant owner and increment the count. If wr_last[owner] or count reaches
//    MAX_BURST: go IDLE, rr_ptr = ~owner.
//    The non-owner writer is never granted while in BURST.
//  - Beat counter is 8 bits and never wraps: a burst ends at MAX_BURST even if
//    wr_last=0. The writer then re-arbitrates.
//  - Reset values: FSM=IDLE, rr_ptr=0 (writer 0 favoured), count=0.
//    ram_en, ram_we, disp_rvalid and wr_gnt = 0. ram_addr, ram_wdata, disp_rdata = 0.
//  - Reset also clears the read pipeline. In-flight reads are dropped and never
//    produce disp_rvalid.
//  - wr_gnt is forced to 0 while rst=1.
//  - There is no back-pressure on display reads. The display must tolerate fixed
//    3-cycle latency only.
// TESTING
//  1. disp_req=1 with disp_addr=5,6,7 on consecutive cycles; RAM model holds mem[a]=a.
//     -> disp_rvalid on cycles +3..+5 with data 5,6,7.
//  2. wr_req=2'b11 from IDLE after reset, no display, each burst 2 beats (wr_last on
//     beat 2). -> gnt order W0,W0,W1,W1,W0,W0. ram_we=1 with matching addr/data one
//     cycle later.
//  3. W0 burst of 20 beats, wr_last=0 throughout, MAX_BURST=8, W1 idle.
//     -> 8 grants, then IDLE. W0 re-wins: beats 9..16, then 17..20 on wr_last.
//  4. W0 mid-burst (beat 3) and disp_req pulses 2 cycles.
//     -> wr_gnt=0 for those 2 cycles, 2 reads issued, W0 resumes at beat 4 with no
//     W1 grant in between.
//  5. WR_VBLANK_ONLY=1, wr_req[1]=1 with vblank=0 for 10 cycles, then vblank=1.
//     -> no grant until vblank rises, grant on the first cycle vblank=1.
//  6. rst asserted while reads are in flight and a W1 burst is open.
//     -> disp_rvalid=0 in all following cycles. After release the FSM is IDLE with
//     rr_ptr=0: W0 wins a tie.

Source files
------------

// File: rtl/fb_access_arbiter_if.sv
// Bundle of signals around the framebuffer RAM arbiter.
//   master : display fetch, the two game-logic writers and the RAM itself
//            (drives requests and ram_rdata, receives grants and RAM commands)
//   slave  : the arbiter (fb_access_arbiter)
// Signals: vblank, disp_req/addr/rvalid/rdata, wr_req/last/addr/data/gnt,
//          ram_en/we/addr/wdata/rdata. Writer i uses bits [i*W +: W] of packed buses.
interface fb_access_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 12
);
   logic                  vblank;
   logic                  disp_req;
   logic [ADDR_W-1:0]     disp_addr;
   logic                  disp_rvalid;
   logic [DATA_W-1:0]     disp_rdata;
   logic [1:0]            wr_req;
   logic [1:0]            wr_last;
   logic [2*ADDR_W-1:0]   wr_addr;
   logic [2*DATA_W-1:0]   wr_data;
   logic [1:0]            wr_gnt;
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_W-1:0]     ram_addr;
   logic [DATA_W-1:0]     ram_wdata;
   logic [DATA_W-1:0]     ram_rdata;

   modport master (
      output vblank, disp_req, disp_addr, wr_req, wr_last, wr_addr, wr_data, ram_rdata,
      input  disp_rvalid, disp_rdata, wr_gnt, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  vblank, disp_req, disp_addr, wr_req, wr_last, wr_addr, wr_data, ram_rdata,
      output disp_rvalid, disp_rdata, wr_gnt, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/fb_access_arbiter.sv
// Framebuffer access arbiter: one single-port RAM (1-cycle read latency) shared by
// the display fetch path (absolute priority, fixed 3-cycle read latency) and two
// writers that share leftover slots round-robin in bursts of up to MAX_BURST beats.
// Ports: clk, rst (synchronous, active-high), bus (fb_access_arbiter_if.slave).
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no writer owns the RAM; arbitrate among eligible writers
// ST_BURST | owner_q holds the RAM for further beats, count in cnt_q
module fb_access_arbiter #(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 12,
   parameter int MAX_BURST      = 8,
   parameter int WR_VBLANK_ONLY = 0
) (
   input logic                 clk,
   input logic                 rst,
   fb_access_arbiter_if.slave  bus
);
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_BURST  = 1'b1;
   localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

   logic [0:0]        state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              owner_q, owner_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        cnt_inc;
   logic [1:0]        gnt;
   logic [1:0]        elig;
   logic              vb_ok;
   logic              sel;
   logic              wr_slot;
   logic              wsel;

   logic              ram_en_q, ram_we_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;
   logic              rd_pend_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;

   assign vb_ok   = (WR_VBLANK_ONLY == 0) || bus.vblank;
   assign elig    = bus.wr_req & {2{vb_ok}};
   assign cnt_inc = cnt_q + 8'd1;
   // Only tie-break through rr_ptr when both writers are eligible.
   assign sel     = (&elig) ? rr_ptr_q : elig[1];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      gnt      = 2'b00;
      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               if (!bus.disp_req && (|elig)) begin
                  gnt[sel] = 1'b1;
                  cnt_d    = 8'd1;
                  if (bus.wr_last[sel] || (MAX_BURST == 1)) begin
                     rr_ptr_d = ~sel;
                  end else begin
                     state_d = ST_BURST;
                     owner_d = sel;
                  end
               end
            end
            default: begin
               // Display slot or a vblank-blocked owner: hold the burst open.
               if (!(bus.disp_req || (bus.wr_req[owner_q] && !vb_ok))) begin
                  if (!bus.wr_req[owner_q]) begin
                     state_d  = ST_IDLE;
                     rr_ptr_d = ~owner_q;
                  end else begin
                     gnt[owner_q] = 1'b1;
                     cnt_d        = cnt_inc;
                     if (bus.wr_last[owner_q] || (cnt_inc >= BURST_MAX)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = ~owner_q;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign wr_slot    = |gnt;
   assign wsel       = gnt[1];
   assign bus.wr_gnt = gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= 1'b0;
         owner_q     <= 1'b0;
         cnt_q       <= 8'd0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rd_pend_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         ram_en_q  <= bus.disp_req | wr_slot;
         ram_we_q  <= ~bus.disp_req & wr_slot;
         if (bus.disp_req) begin
            ram_addr_q <= bus.disp_addr;
         end else if (wr_slot) begin
            ram_addr_q  <= wsel ? bus.wr_addr[ADDR_W +: ADDR_W] : bus.wr_addr[0 +: ADDR_W];
            ram_wdata_q <= wsel ? bus.wr_data[DATA_W +: DATA_W] : bus.wr_data[0 +: DATA_W];
         end
         // RAM read data arrives the cycle after a read command; register it once more.
         rd_pend_q <= ram_en_q & ~ram_we_q;
         rvalid_q  <= rd_pend_q;
         if (rd_pend_q) begin
            rdata_q <= bus.ram_rdata;
         end
      end
   end

   assign bus.ram_en      = ram_en_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_wdata   = ram_wdata_q;
   assign bus.disp_rvalid = rvalid_q;
   assign bus.disp_rdata  = rdata_q;
endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: two instances (writers unrestricted / vblank-only)
// see identical stimulus; a reference model checks both on every cycle.
module tb_fb_access_arbiter;
   localparam int AW = 14;
   localparam int DW = 12;
   localparam int MB = 8;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, vblank, disp_req;
   logic [AW-1:0]   disp_addr;
   logic [1:0]      wr_req, wr_last;
   logic [2*AW-1:0] wr_addr;
   logic [2*DW-1:0] wr_data;
   logic [DW-1:0]   rd_a, rd_b;

   fb_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
   fb_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

   assign ifa.vblank = vblank;   assign ifb.vblank = vblank;
   assign ifa.disp_req = disp_req;   assign ifb.disp_req = disp_req;
   assign ifa.disp_addr = disp_addr; assign ifb.disp_addr = disp_addr;
   assign ifa.wr_req = wr_req;   assign ifb.wr_req = wr_req;
   assign ifa.wr_last = wr_last; assign ifb.wr_last = wr_last;
   assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
   assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
   assign ifa.ram_rdata = rd_a;  assign ifb.ram_rdata = rd_b;

   fb_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .WR_VBLANK_ONLY(0))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   fb_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .WR_VBLANK_ONLY(1))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));

   // RAMs: unwritten words read back as their own address.
   logic [DW-1:0] mem_a [1<<AW];  bit wa [1<<AW];
   logic [DW-1:0] mem_b [1<<AW];  bit wb [1<<AW];
   always @(posedge clk) if (ifa.ram_en) begin
      if (ifa.ram_we) begin mem_a[ifa.ram_addr] <= ifa.ram_wdata; wa[ifa.ram_addr] <= 1'b1; end
      else rd_a <= wa[ifa.ram_addr] ? mem_a[ifa.ram_addr] : DW'(ifa.ram_addr);
   end
   always @(posedge clk) if (ifb.ram_en) begin
      if (ifb.ram_we) begin mem_b[ifb.ram_addr] <= ifb.ram_wdata; wb[ifb.ram_addr] <= 1'b1; end
      else rd_b <= wb[ifb.ram_addr] ? mem_b[ifb.ram_addr] : DW'(ifb.ram_addr);
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- writer stimulus ----------------
   int            w_total [2];
   int            w_done  [2];
   int            w_blen  [2];
   logic [AW-1:0] w_base  [2];
   logic [1:0]    gnt_seen;
   bit            drv_sel;   // whose grants advance the writers: 0 = dut_a, 1 = dut_b

   task automatic drive_wr();
      for (int i = 0; i < 2; i++) begin
         wr_req[i]  = (w_done[i] < w_total[i]);
         wr_last[i] = wr_req[i] && ((w_done[i] % w_blen[i]) == (w_blen[i] - 1));
         wr_addr[i*AW +: AW] = w_base[i] + AW'(w_done[i]);
         wr_data[i*DW +: DW] = DW'(i * 2048 + w_done[i] + 1);
      end
   endtask

   task automatic job(input int i, input int total, input int blen, input logic [AW-1:0] base);
      w_total[i] = total; w_done[i] = 0; w_blen[i] = blen; w_base[i] = base;
      drive_wr();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (gnt_seen[i]) w_done[i]++;
      drive_wr();
   endtask

   task automatic wait_jobs(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (w_done[0] >= w_total[0] && w_done[1] >= w_total[1]) break;
         step();
      end
      cmp("jobs_done_w0", w_done[0], w_total[0]);
      cmp("jobs_done_w1", w_done[1], w_total[1]);
   endtask

   task automatic wait_beats(input int i, input int n, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (w_done[i] >= n) break;
         step();
      end
      cmp("beats_reached", w_done[i], n);
   endtask

   // ---------------- reference model + compare process ----------------
   int            cyc_n = 0;
   bit            m_burst [2];
   int            m_owner [2];
   int            m_beats [2];
   int            m_fav   [2];
   bit            exp_ok  [2];
   bit            exp_en  [2];
   bit            exp_we  [2];
   logic [AW-1:0] exp_addr [2];
   logic [DW-1:0] exp_wd   [2];
   bit            rv_slot [2][4];
   logic [DW-1:0] rd_slot [2][4];
   logic [DW-1:0] ref_mem [2][1<<AW];
   bit            ref_wr  [2][1<<AW];
   int            glog [128];
   int            gcyc [128];
   int            glen = 0;

   logic [1:0]    a_gnt, m_gnt, elig;
   logic          a_en, a_we, a_rv;
   logic [AW-1:0] a_addr, w_a;
   logic [DW-1:0] a_wd, a_rd;
   int            w, s;
   string         tag;

   always @(negedge clk) begin
      cyc_n++;
      gnt_seen = drv_sel ? ifb.wr_gnt : ifa.wr_gnt;
      if (ifa.wr_gnt != 2'b00 && glen < 128) begin
         glog[glen] = ifa.wr_gnt[1] ? 1 : 0;
         gcyc[glen] = cyc_n;
         glen++;
      end
      for (int d = 0; d < 2; d++) begin
         tag = (d == 0) ? "a" : "b";
         if (d == 0) begin
            a_gnt = ifa.wr_gnt; a_en = ifa.ram_en; a_we = ifa.ram_we; a_addr = ifa.ram_addr;
            a_wd = ifa.ram_wdata; a_rv = ifa.disp_rvalid; a_rd = ifa.disp_rdata;
         end else begin
            a_gnt = ifb.wr_gnt; a_en = ifb.ram_en; a_we = ifb.ram_we; a_addr = ifb.ram_addr;
            a_wd = ifb.ram_wdata; a_rv = ifb.disp_rvalid; a_rd = ifb.disp_rdata;
         end
         // Writer eligibility: instance b only lets writers in during vblank.
         elig  = ((d == 0) || vblank) ? wr_req : 2'b00;
         m_gnt = 2'b00;
         if (rst) begin
            m_burst[d] = 1'b0; m_fav[d] = 0; m_beats[d] = 0;
         end else if (!m_burst[d]) begin
            if (!disp_req && elig != 2'b00) begin
               w = (elig == 2'b11) ? m_fav[d] : (elig[0] ? 0 : 1);
               m_gnt[w] = 1'b1;
               m_beats[d] = 1;
               if (wr_last[w] || MB == 1) m_fav[d] = 1 - w;
               else begin m_burst[d] = 1'b1; m_owner[d] = w; end
            end
         end else begin
            w = m_owner[d];
            if (!(disp_req || (wr_req[w] && !elig[w]))) begin
               if (!wr_req[w]) begin
                  m_burst[d] = 1'b0; m_fav[d] = 1 - w;
               end else begin
                  m_gnt[w] = 1'b1;
                  m_beats[d] = m_beats[d] + 1;
                  if (wr_last[w] || m_beats[d] == MB) begin
                     m_burst[d] = 1'b0; m_fav[d] = 1 - w;
                  end
               end
            end
         end

         cmp({tag, ".wr_gnt"}, a_gnt, m_gnt);
         if (exp_ok[d]) begin
            cmp({tag, ".ram_en"}, a_en, exp_en[d]);
            cmp({tag, ".ram_we"}, a_we, exp_we[d]);
            if (exp_en[d]) cmp({tag, ".ram_addr"}, a_addr, exp_addr[d]);
            if (exp_we[d]) cmp({tag, ".ram_wdata"}, a_wd, exp_wd[d]);
         end
         s = cyc_n % 4;
         cmp({tag, ".disp_rvalid"}, a_rv, rv_slot[d][s]);
         if (rv_slot[d][s]) cmp({tag, ".disp_rdata"}, a_rd, rd_slot[d][s]);
         rv_slot[d][s] = 1'b0;

         exp_ok[d] = 1'b1;
         if (rst) begin
            exp_en[d] = 1'b0; exp_we[d] = 1'b0;
            for (int k = 0; k < 4; k++) rv_slot[d][k] = 1'b0;
         end else if (disp_req) begin
            exp_en[d] = 1'b1; exp_we[d] = 1'b0; exp_addr[d] = disp_addr;
            rv_slot[d][(cyc_n + 3) % 4] = 1'b1;
            rd_slot[d][(cyc_n + 3) % 4] = ref_wr[d][disp_addr] ? ref_mem[d][disp_addr]
                                                               : DW'(disp_addr);
         end else if (m_gnt != 2'b00) begin
            w = m_gnt[1] ? 1 : 0;
            w_a = wr_addr[w*AW +: AW];
            exp_en[d] = 1'b1; exp_we[d] = 1'b1; exp_addr[d] = w_a;
            exp_wd[d] = wr_data[w*DW +: DW];
            ref_mem[d][w_a] = wr_data[w*DW +: DW];
            ref_wr[d][w_a] = 1'b1;
         end else begin
            exp_en[d] = 1'b0; exp_we[d] = 1'b0;
         end
      end
   end

   // ---------------- directed tests ----------------
   int t2_exp [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
   int gstart;

   initial begin
      rst = 1'b1; vblank = 1'b1; disp_req = 1'b0; disp_addr = '0; drv_sel = 1'b0;
      gnt_seen = 2'b00;
      for (int i = 0; i < 2; i++) begin
         w_total[i] = 0; w_done[i] = 0; w_blen[i] = 1; w_base[i] = '0;
      end
      drive_wr();
      repeat (3) step();
      @(negedge clk);
      cmp("rst.wr_gnt", ifa.wr_gnt, 0);
      cmp("rst.ram_en", ifa.ram_en, 0);
      cmp("rst.ram_we", ifa.ram_we, 0);
      cmp("rst.ram_addr", ifa.ram_addr, 0);
      cmp("rst.ram_wdata", ifa.ram_wdata, 0);
      cmp("rst.disp_rvalid", ifa.disp_rvalid, 0);
      cmp("rst.disp_rdata", ifa.disp_rdata, 0);
      cmp("rst.b_ram_en", ifb.ram_en, 0);
      step();
      rst = 1'b0;
      step();

      // 1: three back-to-back display reads, data appears 3 cycles later
      disp_req = 1'b1; disp_addr = 14'd5; step();
      disp_addr = 14'd6; step();
      disp_addr = 14'd7; step();
      disp_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         cmp("t1.rvalid", ifa.disp_rvalid, 1);
         cmp("t1.rdata", ifa.disp_rdata, 5 + k);
         step();
      end
      @(negedge clk);
      cmp("t1.rvalid_end", ifa.disp_rvalid, 0);
      step();

      // 2: both writers, 2-beat bursts, round-robin
      gstart = glen;
      job(0, 4, 2, 14'h100);
      job(1, 4, 2, 14'h200);
      wait_jobs(40);
      step();
      cmp("t2.grants", glen - gstart, 8);
      for (int k = 0; k < 8; k++) cmp("t2.order", glog[gstart + k], t2_exp[k]);

      // 3: W0 20 beats, no wr_last until the end; W1 one beat waiting
      gstart = glen;
      job(0, 20, 20, 14'h300);
      job(1, 1, 1, 14'h3F0);
      wait_jobs(60);
      step();
      cmp("t3.grants", glen - gstart, 21);
      for (int k = 0; k < 21; k++) cmp("t3.order", glog[gstart + k], (k == 8) ? 1 : 0);
      cmp("t3.no_gaps", gcyc[gstart + 20] - gcyc[gstart], 20);

      // 4: display preempts W0 mid-burst for 2 cycles
      gstart = glen;
      job(0, 6, 6, 14'h400);
      wait_beats(0, 3, 20);
      disp_req = 1'b1; disp_addr = 14'd20;
      job(1, 1, 1, 14'h410);
      step();
      disp_addr = 14'd21; step();
      disp_req = 1'b0;
      wait_jobs(40);
      step();
      cmp("t4.grants", glen - gstart, 7);
      for (int k = 0; k < 7; k++) cmp("t4.order", glog[gstart + k], (k == 6) ? 1 : 0);
      cmp("t4.pause", gcyc[gstart + 3] - gcyc[gstart + 2], 3);
      cmp("t4.w1_after", gcyc[gstart + 6] - gcyc[gstart + 5], 1);

      // 5: vblank-only instance waits for vblank
      drv_sel = 1'b1;
      vblank = 1'b0;
      job(1, 3, 1, 14'h500);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         cmp("t5.no_grant", ifb.wr_gnt, 0);
         step();
      end
      vblank = 1'b1;
      @(negedge clk);
      cmp("t5.first_grant", ifb.wr_gnt, 2'b10);
      wait_jobs(20);
      drv_sel = 1'b0;
      step();

      // 6: reset with reads in flight and a W1 burst open
      job(1, 10, 10, 14'h600);
      wait_beats(1, 2, 20);
      disp_req = 1'b1; disp_addr = 14'd30; step();
      disp_addr = 14'd31; step();
      disp_req = 1'b0;
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         cmp("t6.a_rvalid", ifa.disp_rvalid, 0);
         cmp("t6.b_rvalid", ifb.disp_rvalid, 0);
         if (k < 2) cmp("t6.gnt_in_rst", ifa.wr_gnt, 0);
         if (k == 2) begin
            cmp("t6.a_tie_w0", ifa.wr_gnt, 2'b01);
            cmp("t6.b_tie_w0", ifb.wr_gnt, 2'b01);
         end
         step();
         if (k == 1) begin
            rst = 1'b0;
            job(0, 1, 1, 14'h700);
         end
      end
      wait_jobs(40);
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
